// File: rtl/spk_window_counter.sv
// Windowed spike counter: sums popcount(fan_in) over a programmable window and hands results over valid/ready.
// Define SPK_WINDOW_COUNTER_SAT_EN to clamp the accumulator at 2^CNT_W-1 instead of wrapping.
module spk_window_counter #(
    parameter int NUM   = 8,
    parameter int CNT_W = 16,
    parameter int WIN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIN_W-1:0] win_len,
    input  logic [NUM-1:0]   fan_in,
    output logic [7:0]       pop_now,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    input  logic             count_ready,
    output logic             overrun,
    output logic             busy
);

    localparam int POP_W = $clog2(NUM + 1);
    localparam int SUM_W = CNT_W + 1;

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] acc;
    logic [WIN_W-1:0] cyc;
    logic [WIN_W-1:0] len;

    logic [POP_W-1:0] pop;
    logic [8:0]       pop_ext;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] acc_next;
    logic [WIN_W-1:0] len_eff;
    logic             last;
    logic             formed;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM; i++) begin
            pop = pop + POP_W'(fan_in[i]);
        end
    end

    assign pop_ext = 9'(pop);
    assign sum     = {1'b0, acc} + SUM_W'(pop);

    // The carry out of the widened sum tells us the running total no longer fits.
    always_comb begin
`ifdef SPK_WINDOW_COUNTER_SAT_EN
        acc_next = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
`else
        acc_next = sum[CNT_W-1:0];
`endif
    end

    assign len_eff = (win_len == '0) ? WIN_W'(1) : win_len;
    assign last    = (cyc == len - WIN_W'(1));
    assign formed  = (state == ACCUM) && en && last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            cyc         <= '0;
            len         <= WIN_W'(1);
            pop_now     <= '0;
            count_out   <= '0;
            count_valid <= 1'b0;
            overrun     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            pop_now <= pop_ext[7:0];

            case (state)
                IDLE: begin
                    if (en) begin
                        state <= ACCUM;
                        busy  <= 1'b1;
                        len   <= len_eff;
                        acc   <= '0;
                        cyc   <= '0;
                    end
                end
                ACCUM: begin
                    if (!en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (last) begin
                        // Next window starts on the very next cycle with a fresh length.
                        acc <= '0;
                        cyc <= '0;
                        len <= len_eff;
                    end else begin
                        acc <= acc_next;
                        cyc <= cyc + WIN_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (formed) begin
                if (!count_valid || count_ready) begin
                    count_out   <= acc_next;
                    count_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (count_valid && count_ready) begin
                count_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spk_window_counter.sv
// Self-checking bench for spk_window_counter: two instances (CNT_W=16 and CNT_W=4) share stimulus
// and are compared every cycle against a window-level behavioural model.
module tb_spk_window_counter;

    localparam int NUM   = 8;
    localparam int WIN_W = 8;
    localparam int CW0   = 16;
    localparam int CW1   = 4;

    logic             clk         = 1'b0;
    logic             rst_n       = 1'b0;
    logic             en          = 1'b0;
    logic             count_ready = 1'b0;
    logic [WIN_W-1:0] win_len     = '0;
    logic [NUM-1:0]   fan_in      = '0;

    logic [7:0]     pop0, pop1;
    logic [CW0-1:0] out0;
    logic [CW1-1:0] out1;
    logic           v0, v1, o0, o1, b0, b1;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // Window-level model: totals are unbounded integers, folded to each instance width on compare.
    bit     m_in_win  = 1'b0;
    int     m_len     = 1;
    int     m_elapsed = 0;
    longint m_total   = 0;
    bit     m_valid   = 1'b0;
    longint m_result  = 0;
    bit     m_ovr     = 1'b0;
    int     m_pop     = 0;

    always #5 clk = ~clk;

    spk_window_counter #(.NUM(NUM), .CNT_W(CW0), .WIN_W(WIN_W)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .win_len(win_len), .fan_in(fan_in),
        .pop_now(pop0), .count_out(out0), .count_valid(v0), .count_ready(count_ready),
        .overrun(o0), .busy(b0)
    );

    spk_window_counter #(.NUM(NUM), .CNT_W(CW1), .WIN_W(WIN_W)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .win_len(win_len), .fan_in(fan_in),
        .pop_now(pop1), .count_out(out1), .count_valid(v1), .count_ready(count_ready),
        .overrun(o1), .busy(b1)
    );

    function automatic longint fold(input longint t, input int cw);
        longint span;
        span = longint'(1) << cw;
`ifdef SPK_WINDOW_COUNTER_SAT_EN
        return (t > span - 1) ? span - 1 : t;
`else
        return t % span;
`endif
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit e, input int wl, input logic [NUM-1:0] fi, input bit rdy);
        en          = e;
        win_len     = WIN_W'(wl);
        fan_in      = fi;
        count_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic goIdle();
        applyStimulus(1'b0, 0, '0, 1'b1);
        tick();
        tick();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".pop0"}, pop0, 0);
        checkOutput({tag, ".out0"}, out0, 0);
        checkOutput({tag, ".valid0"}, v0, 0);
        checkOutput({tag, ".ovr0"}, o0, 0);
        checkOutput({tag, ".busy0"}, b0, 0);
        checkOutput({tag, ".out1"}, out1, 0);
        checkOutput({tag, ".valid1"}, v1, 0);
        checkOutput({tag, ".busy1"}, b1, 0);
    endtask

    always @(posedge clk) begin
        int     pop;
        bit     formed;
        longint res;
        if (!rst_n) begin
            m_in_win  = 1'b0;
            m_len     = 1;
            m_elapsed = 0;
            m_total   = 0;
            m_valid   = 1'b0;
            m_result  = 0;
            m_ovr     = 1'b0;
            m_pop     = 0;
        end else begin
            pop    = $countones(fan_in);
            formed = 1'b0;
            res    = 0;
            if (!m_in_win) begin
                if (en) begin
                    m_in_win  = 1'b1;
                    m_len     = (win_len == 0) ? 1 : int'(win_len);
                    m_elapsed = 0;
                    m_total   = 0;
                end
            end else if (!en) begin
                m_in_win = 1'b0;
            end else begin
                m_total   = m_total + pop;
                m_elapsed = m_elapsed + 1;
                if (m_elapsed == m_len) begin
                    formed    = 1'b1;
                    res       = m_total;
                    m_total   = 0;
                    m_elapsed = 0;
                    m_len     = (win_len == 0) ? 1 : int'(win_len);
                end
            end
            if (formed) begin
                if (!m_valid || count_ready) begin
                    m_valid  = 1'b1;
                    m_result = res;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && count_ready) begin
                m_valid = 1'b0;
            end
            m_pop = pop % 256;
        end
    end

    always @(posedge clk) begin
        #2;
        if (rst_n && chk_on) begin
            checkOutput("cmp.pop0", pop0, m_pop);
            checkOutput("cmp.out0", out0, fold(m_result, CW0));
            checkOutput("cmp.valid0", v0, m_valid);
            checkOutput("cmp.ovr0", o0, m_ovr);
            checkOutput("cmp.busy0", b0, m_in_win);
            checkOutput("cmp.pop1", pop1, m_pop);
            checkOutput("cmp.out1", out1, fold(m_result, CW1));
            checkOutput("cmp.valid1", v1, m_valid);
            checkOutput("cmp.ovr1", o1, m_ovr);
            checkOutput("cmp.busy1", b1, m_in_win);
        end
    end

    initial begin
        int vcnt;
        applyStimulus(1'b0, 0, '0, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        checkAllZero("reset");
        chk_on = 1'b1;

        // Four-cycle windows of 4 spikes per cycle, consumer always ready.
        applyStimulus(1'b1, 4, 8'h0F, 1'b1);
        vcnt = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (v0) vcnt++;
            if (t == 1) checkOutput("req033.busy", b0, 1);
            if (t == 5) begin
                checkOutput("req033.out", out0, 16);
                checkOutput("req033.valid", v0, 1);
            end
            if (t == 6) checkOutput("req033.valid_drop", v0, 0);
        end
        checkOutput("req033.pulses", vcnt, 2);
        goIdle();

        // Zero length behaves as one-cycle windows.
        applyStimulus(1'b1, 0, 8'hFF, 1'b1);
        for (int t = 1; t <= 4; t++) begin
            tick();
            if (t >= 2) begin
                checkOutput("req034.out", out0, 8);
                checkOutput("req034.valid", v0, 1);
                checkOutput("req034.out1", out1, 8);
            end
        end
        checkOutput("req034.pop", pop0, 8);
        goIdle();

        // Abandoned window.
        applyStimulus(1'b1, 5, 8'hFF, 1'b1);
        tick();
        tick();
        tick();
        checkOutput("req036.busy_on", b0, 1);
        applyStimulus(1'b0, 5, 8'hFF, 1'b1);
        tick();
        checkOutput("req036.busy_off", b0, 0);
        checkOutput("req036.valid", v0, 0);
        checkOutput("req036.ovr", o0, 0);
        tick();
        checkOutput("req036.valid_later", v0, 0);
        checkOutput("req036.ovr_later", o0, 0);

        // Narrow accumulator: 24 spikes in a 4-bit counter.
        applyStimulus(1'b1, 3, 8'hFF, 1'b1);
        repeat (4) tick();
        checkOutput("req037.out0", out0, 24);
        checkOutput("req037.valid1", v1, 1);
`ifdef SPK_WINDOW_COUNTER_SAT_EN
        checkOutput("req037.out1_sat", out1, 15);
`else
        checkOutput("req037.out1_wrap", out1, 8);
`endif
        goIdle();

        // Backpressure: second result dropped, first one held then consumed once.
        applyStimulus(1'b1, 2, 8'h03, 1'b0);
        repeat (3) tick();
        checkOutput("req035.first_out", out0, 4);
        checkOutput("req035.first_valid", v0, 1);
        checkOutput("req035.no_ovr_yet", o0, 0);
        applyStimulus(1'b1, 2, 8'h01, 1'b0);
        tick();
        tick();
        checkOutput("req035.ovr", o0, 1);
        checkOutput("req035.held_out", out0, 4);
        tick();
        checkOutput("req035.still_held", out0, 4);
        checkOutput("req035.still_valid", v0, 1);
        applyStimulus(1'b0, 2, 8'h01, 1'b1);
        tick();
        checkOutput("req035.consumed", v0, 0);
        checkOutput("req035.ovr_sticky", o0, 1);
        tick();
        tick();
        checkOutput("req035.once", v0, 0);

        // Asynchronous reset mid-window with a pending result.
        applyStimulus(1'b1, 2, 8'hFF, 1'b0);
        repeat (4) tick();
        checkOutput("req038.pre_valid", v0, 1);
        checkOutput("req038.pre_busy", b0, 1);
        #3;
        rst_n = 1'b0;
        #1;
        checkAllZero("req038");
        checkOutput("req038.ovr1", o1, 0);
        checkOutput("req038.pop1", pop1, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Randomised traffic against the model.
        for (int n = 0; n < 800; n++) begin
            applyStimulus($urandom_range(0, 9) != 0, int'($urandom_range(0, 6)),
                          8'($urandom), $urandom_range(0, 9) < 7);
            tick();
        end

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
